// File: rtl/apb4_regfile_slave_if.sv
// APB4 completer-side bus bundle for apb4_regfile_slave.
// The requester drives the select/address/data group; the completer returns the response group.
interface apb4_regfile_slave_if #(
  parameter int DW = 32
);
  logic            PSELx_i;
  logic [31:0]     PADDR_i;
  logic            PENABLE_i;
  logic            PWRITE_i;
  logic [2:0]      PPROT_i;
  logic [DW-1:0]   PWDATA_i;
  logic [DW/8-1:0] PSTRB_i;
  logic            PREADY_o;
  logic [DW-1:0]   PRDATA_o;
  logic            PSLVERR_o;

  modport master (
    output PSELx_i, PADDR_i, PENABLE_i, PWRITE_i, PPROT_i, PWDATA_i, PSTRB_i,
    input  PREADY_o, PRDATA_o, PSLVERR_o
  );

  modport slave (
    input  PSELx_i, PADDR_i, PENABLE_i, PWRITE_i, PPROT_i, PWDATA_i, PSTRB_i,
    output PREADY_o, PRDATA_o, PSLVERR_o
  );
endinterface

// File: rtl/apb4_regfile_slave.sv
// APB4 register-file completer: CTRL, saturating ERRCNT and DEPTH data words,
// with programmable wait states, byte strobes, a secure-access filter and PSLVERR.
module apb4_regfile_slave #(
  parameter int          DW          = 32,
  parameter int          DEPTH       = 16,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter logic [3:0]  WAIT_STATES = 4'd0
) (
  input  logic                PCLK_i,
  input  logic                PRESET_i,
  apb4_regfile_slave_if.slave apb
);
  localparam int          IW        = $clog2(DEPTH);
  localparam logic [29:0] LAST_WORD = 30'(DEPTH + 1);

  // The APB setup cycle is the SETUP phase: its latch/load work happens on the
  // edge that enters ACCESS, so only IDLE and ACCESS are ever held.
  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ACCESS = 1'b1;

  logic [0:0]      state_q;
  logic [3:0]      cnt_q;
  logic [31:0]     addr_q;
  logic            write_q;
  logic            nonsec_q;
  logic [DW-1:0]   wdata_q;
  logic [DW/8-1:0] strb_q;
  logic [3:0]      ctrl_wait_q;
  logic            ctrl_sec_q;
  logic            ctrl_lock_q;
  logic [15:0]     errcnt_q;
  logic [15:0]     errcnt_d;
  logic [DW-1:0]   data_q [DEPTH];

  logic            setup;
  logic            commit;
  logic            accept;
  logic            abort;
  logic [31:0]     offset;
  logic [29:0]     word;
  logic            aligned;
  logic            is_ctrl;
  logic            is_errcnt;
  logic            is_data;
  logic [IW-1:0]   idx;
  logic            err;
  logic [DW-1:0]   rdata;
  logic            unused_prot;

  assign setup  = apb.PSELx_i & ~apb.PENABLE_i;
  assign commit = (state_q == ST_ACCESS) && (cnt_q == 4'd0);
  assign accept = setup && ((state_q == ST_IDLE) || commit);
  assign abort  = (state_q == ST_ACCESS) && !commit && !(apb.PSELx_i && apb.PENABLE_i);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge PCLK_i) begin
    if (PRESET_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else if (accept) begin
      state_q <= ST_ACCESS;
      cnt_q   <= ctrl_wait_q;
    end else if (commit || abort) begin
      state_q <= ST_IDLE;
    end else if (state_q == ST_ACCESS) begin
      cnt_q <= cnt_q - 4'd1;
    end
  end

  // Request capture carries no reset: it is only observed while ACCESS is held.
  always_ff @(posedge PCLK_i) begin
    if (accept) begin
      addr_q   <= apb.PADDR_i;
      write_q  <= apb.PWRITE_i;
      nonsec_q <= apb.PPROT_i[1];
      wdata_q  <= apb.PWDATA_i;
      strb_q   <= apb.PSTRB_i;
    end
  end

  assign unused_prot = ^{apb.PPROT_i[2], apb.PPROT_i[0]};

  assign offset    = addr_q - BASE_ADDR;
  assign word      = offset[31:2];
  assign aligned   = (offset[1:0] == 2'b00);
  assign is_ctrl   = aligned && (word == 30'd0);
  assign is_errcnt = aligned && (word == 30'd1);
  assign is_data   = aligned && (word >= 30'd2) && (word <= LAST_WORD);
  assign idx       = IW'(word - 30'd2);

  assign err = (word > LAST_WORD) || !aligned || (ctrl_sec_q && nonsec_q)
            || (write_q && is_data && ctrl_lock_q);

  // NOTE: combinational blocks assign a default first so no path leaves a latch behind.
  always_comb begin
    errcnt_d = errcnt_q;
    if (commit) begin
      if (err) begin
        if (errcnt_q != 16'hFFFF) errcnt_d = errcnt_q + 16'd1;
      end else if (write_q && is_errcnt) begin
        errcnt_d = '0;
      end
    end
  end

  // NOTE: the data array is reset explicitly because reads after reset must return 0.
  always_ff @(posedge PCLK_i) begin
    if (PRESET_i) begin
      ctrl_wait_q <= WAIT_STATES;
      ctrl_sec_q  <= 1'b0;
      ctrl_lock_q <= 1'b0;
      errcnt_q    <= '0;
      for (int i = 0; i < DEPTH; i++) data_q[i] <= '0;
    end else begin
      errcnt_q <= errcnt_d;
      if (commit && write_q && !err) begin
        if (is_ctrl && strb_q[0]) begin
          {ctrl_lock_q, ctrl_sec_q, ctrl_wait_q} <= wdata_q[5:0];
        end
        if (is_data) begin
          for (int b = 0; b < DW/8; b++) begin
            if (strb_q[b]) data_q[idx][8*b +: 8] <= wdata_q[8*b +: 8];
          end
        end
      end
    end
  end

  always_comb begin
    rdata = '0;
    if (is_ctrl)        rdata[5:0]  = {ctrl_lock_q, ctrl_sec_q, ctrl_wait_q};
    else if (is_errcnt) rdata[15:0] = errcnt_q;
    else if (is_data)   rdata       = data_q[idx];
  end

  // Responses are pure decodes of held state, so they stay zero outside the commit cycle.
  assign apb.PREADY_o  = commit;
  assign apb.PSLVERR_o = commit && err;
  assign apb.PRDATA_o  = (commit && !err && !write_q) ? rdata : '0;
endmodule

// File: tb/tb_apb4_regfile_slave.sv
// Self-checking bench for apb4_regfile_slave: a negedge monitor pops expected
// responses from a scoreboard queue; scenario tasks check latency and side effects.
module tb_apb4_regfile_slave;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  apb4_regfile_slave_if #(.DW(32)) apb ();

  apb4_regfile_slave #(
    .DW(32), .DEPTH(DEPTH), .BASE_ADDR(32'h0000_0000), .WAIT_STATES(4'd0)
  ) dut (
    .PCLK_i  (clk),
    .PRESET_i(rst),
    .apb     (apb)
  );

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic [7:0]  tag;
  } resp_t;

  resp_t exp_q[$];
  resp_t exp_item;
  int    checks    = 0;
  int    failures  = 0;
  int    ready_cnt = 0;
  int    idle_viol = 0;
  int    cycle     = 0;
  logic [7:0] tag  = 8'd0;

  always @(posedge clk) cycle++;

  // Scoreboard: every PREADY pulse must match the oldest expected response.
  always @(negedge clk) begin
    if (apb.PREADY_o === 1'b1) begin
      ready_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL resp_unexpected got rdata=%h err=%b, required no PREADY pulse",
                 apb.PRDATA_o, apb.PSLVERR_o);
      end else begin
        exp_item = exp_q.pop_front();
        if (apb.PRDATA_o !== exp_item.rdata || apb.PSLVERR_o !== exp_item.err) begin
          failures++;
          $display("FAIL resp_tag%0d got rdata=%h err=%b, required rdata=%h err=%b",
                   exp_item.tag, apb.PRDATA_o, apb.PSLVERR_o, exp_item.rdata, exp_item.err);
        end
      end
    end else if (apb.PRDATA_o !== 32'h0 || apb.PSLVERR_o !== 1'b0) begin
      idle_viol++;
    end
  end

  task automatic idle(input int n);
    apb.PSELx_i   = 1'b0;
    apb.PENABLE_i = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Runs one transfer from posedge+1 and returns at posedge+1 after the commit edge,
  // leaving the bus in its access phase so a following call is back-to-back.
  task automatic xfer(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                      input logic [3:0] strb, input logic [2:0] prot,
                      input logic exp_err, input logic [31:0] exp_rdata, output int acc);
    bit done = 1'b0;
    tag++;
    exp_q.push_back('{rdata: exp_rdata, err: exp_err, tag: tag});
    apb.PSELx_i   = 1'b1;
    apb.PENABLE_i = 1'b0;
    apb.PADDR_i   = addr;
    apb.PWRITE_i  = wr;
    apb.PWDATA_i  = wdata;
    apb.PSTRB_i   = strb;
    apb.PPROT_i   = prot;
    @(posedge clk); #1;
    apb.PENABLE_i = 1'b1;
    acc = 0;
    while (!done && acc < 40) begin
      acc++;
      @(negedge clk);
      if (apb.PREADY_o === 1'b1) done = 1'b1;
      @(posedge clk); #1;
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL xfer_timeout tag=%0d addr=%h got no PREADY in 40 cycles, required one",
               tag, addr);
      exp_q.delete(exp_q.size() - 1);
      apb.PSELx_i   = 1'b0;
      apb.PENABLE_i = 1'b0;
      acc = -1;
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                    input logic [2:0] p, input logic e, output int acc);
    xfer(a, 1'b1, d, s, p, e, 32'h0, acc);
  endtask

  task automatic rd(input logic [31:0] a, input logic [2:0] p, input logic e,
                    input logic [31:0] x, output int acc);
    xfer(a, 1'b0, 32'h0, 4'h0, p, e, x, acc);
  endtask

  task automatic test_reset();
    int acc;
    rst = 1'b1;
    idle(3);
    @(negedge clk);
    checks++; if (apb.PREADY_o !== 1'b0) begin failures++; $display("FAIL reset_pready got %b required 0", apb.PREADY_o); end
    checks++; if (apb.PRDATA_o !== 32'h0) begin failures++; $display("FAIL reset_prdata got %h required 0", apb.PRDATA_o); end
    checks++; if (apb.PSLVERR_o !== 1'b0) begin failures++; $display("FAIL reset_pslverr got %b required 0", apb.PSLVERR_o); end
    @(posedge clk); #1;
    rst = 1'b0;
    rd(32'h00, 3'b000, 1'b0, 32'h0, acc);
    rd(32'h04, 3'b000, 1'b0, 32'h0, acc);
    rd(32'h44, 3'b000, 1'b0, 32'h0, acc);
    idle(1);
  endtask

  task automatic test_reset_midxfer();
    int acc;
    int rc;
    wr(32'h00, 32'h2, 4'hF, 3'b000, 1'b0, acc);
    apb.PSELx_i = 1'b1; apb.PENABLE_i = 1'b0; apb.PADDR_i = 32'h1C; apb.PWRITE_i = 1'b1;
    apb.PWDATA_i = 32'hFFFF_FFFF; apb.PSTRB_i = 4'hF; apb.PPROT_i = 3'b000;
    @(posedge clk); #1;
    apb.PENABLE_i = 1'b1;
    rc = ready_cnt;
    @(posedge clk); #1;
    rst = 1'b1;
    apb.PSELx_i = 1'b0; apb.PENABLE_i = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (apb.PREADY_o !== 1'b0) begin failures++; $display("FAIL midreset_pready got %b required 0", apb.PREADY_o); end
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if (ready_cnt != rc) begin failures++; $display("FAIL midreset_pulses got %0d required %0d", ready_cnt, rc); end
    rd(32'h00, 3'b000, 1'b0, 32'h0, acc);
    checks++; if (acc != 1) begin failures++; $display("FAIL midreset_wait_cleared got %0d access cycles required 1", acc); end
    rd(32'h1C, 3'b000, 1'b0, 32'h0, acc);
    idle(1);
  endtask

  task automatic test_basic();
    int acc;
    wr(32'h08, 32'hDEAD_BEEF, 4'hF, 3'b000, 1'b0, acc);
    checks++; if (acc != 1) begin failures++; $display("FAIL basic_write_latency got %0d required 1", acc); end
    idle(1);
    rd(32'h08, 3'b000, 1'b0, 32'hDEAD_BEEF, acc);
    checks++; if (acc != 1) begin failures++; $display("FAIL basic_read_latency got %0d required 1", acc); end
    idle(1);
  endtask

  task automatic test_wait_strobe();
    int acc;
    wr(32'h00, 32'h0000_0003, 4'hF, 3'b000, 1'b0, acc);
    wr(32'h0C, 32'h1122_3344, 4'b0101, 3'b000, 1'b0, acc);
    checks++; if (acc != 4) begin failures++; $display("FAIL wait3_write_latency got %0d required 4", acc); end
    rd(32'h0C, 3'b000, 1'b0, 32'h0022_0044, acc);
    wr(32'h0C, 32'hFFFF_FFFF, 4'b0000, 3'b000, 1'b0, acc);
    rd(32'h0C, 3'b000, 1'b0, 32'h0022_0044, acc);
    wr(32'h00, 32'h0, 4'hF, 3'b000, 1'b0, acc);
    checks++; if (acc != 4) begin failures++; $display("FAIL wait3_ctrl_write_latency got %0d required 4", acc); end
    rd(32'h00, 3'b000, 1'b0, 32'h0, acc);
    checks++; if (acc != 1) begin failures++; $display("FAIL wait0_restored got %0d required 1", acc); end
    idle(1);
  endtask

  task automatic test_errors();
    int acc;
    wr(32'h04, 32'h0, 4'hF, 3'b000, 1'b0, acc);
    rd(32'h08 + 4 * DEPTH, 3'b000, 1'b1, 32'h0, acc);
    rd(32'h0A, 3'b000, 1'b1, 32'h0, acc);
    rd(32'h04, 3'b000, 1'b0, 32'd2, acc);
    idle(1);
  endtask

  task automatic test_secure();
    int acc;
    wr(32'h00, 32'h0000_0010, 4'hF, 3'b000, 1'b0, acc);
    wr(32'h08, 32'h1234_5678, 4'hF, 3'b010, 1'b1, acc);
    rd(32'h08, 3'b000, 1'b0, 32'hDEAD_BEEF, acc);
    wr(32'h08, 32'h1234_5678, 4'hF, 3'b000, 1'b0, acc);
    rd(32'h08, 3'b000, 1'b0, 32'h1234_5678, acc);
    rd(32'h08, 3'b010, 1'b1, 32'h0, acc);
    wr(32'h00, 32'h0000_0020, 4'hF, 3'b000, 1'b0, acc);
    wr(32'h08, 32'h0, 4'hF, 3'b000, 1'b1, acc);
    rd(32'h08, 3'b000, 1'b0, 32'h1234_5678, acc);
    wr(32'h00, 32'h0, 4'hF, 3'b000, 1'b0, acc);
    rd(32'h04, 3'b000, 1'b0, 32'd5, acc);
    idle(1);
  endtask

  task automatic test_abort();
    int acc;
    int rc;
    wr(32'h00, 32'h0000_0005, 4'hF, 3'b000, 1'b0, acc);
    idle(1);
    rc = ready_cnt;
    apb.PSELx_i = 1'b1; apb.PENABLE_i = 1'b0; apb.PADDR_i = 32'h10; apb.PWRITE_i = 1'b1;
    apb.PWDATA_i = 32'hAAAA_5555; apb.PSTRB_i = 4'hF; apb.PPROT_i = 3'b000;
    @(posedge clk); #1;
    apb.PENABLE_i = 1'b1;
    @(posedge clk); #1;
    apb.PSELx_i = 1'b0;
    idle(10);
    checks++; if (ready_cnt != rc) begin failures++; $display("FAIL abort_pulses got %0d required %0d", ready_cnt, rc); end
    rd(32'h10, 3'b000, 1'b0, 32'h0, acc);
    checks++; if (acc != 6) begin failures++; $display("FAIL wait5_read_latency got %0d required 6", acc); end
    rd(32'h04, 3'b000, 1'b0, 32'd5, acc);
    wr(32'h00, 32'h0, 4'hF, 3'b000, 1'b0, acc);
    idle(1);
  endtask

  task automatic test_back_to_back();
    int acc;
    int start;
    start = cycle;
    wr(32'h14, 32'h0102_0304, 4'hF, 3'b000, 1'b0, acc);
    wr(32'h18, 32'h0A0B_0C0D, 4'hF, 3'b000, 1'b0, acc);
    rd(32'h14, 3'b000, 1'b0, 32'h0102_0304, acc);
    rd(32'h18, 3'b000, 1'b0, 32'h0A0B_0C0D, acc);
    checks++; if (cycle - start != 8) begin failures++; $display("FAIL b2b_cycles got %0d required 8", cycle - start); end
    idle(1);
  endtask

  task automatic test_errcnt_saturation();
    int acc;
    wr(32'h04, 32'h0, 4'hF, 3'b000, 1'b0, acc);
    idle(1);
    force dut.errcnt_q = 16'hFFFD;
    @(posedge clk); #1;
    release dut.errcnt_q;
    idle(1);
    rd(32'h04, 3'b000, 1'b0, 32'h0000_FFFD, acc);
    rd(32'h0A, 3'b000, 1'b1, 32'h0, acc);
    rd(32'h0A, 3'b000, 1'b1, 32'h0, acc);
    rd(32'h04, 3'b000, 1'b0, 32'h0000_FFFF, acc);
    rd(32'h0A, 3'b000, 1'b1, 32'h0, acc);
    rd(32'h04, 3'b000, 1'b0, 32'h0000_FFFF, acc);
    wr(32'h04, 32'h0, 4'hF, 3'b000, 1'b0, acc);
    rd(32'h04, 3'b000, 1'b0, 32'h0, acc);
    idle(1);
  endtask

  task automatic test_idle_outputs();
    idle(2);
    checks++; if (idle_viol != 0) begin failures++; $display("FAIL idle_outputs got %0d nonzero cycles required 0", idle_viol); end
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL pending_responses got %0d required 0", exp_q.size()); end
  endtask

  initial begin
    apb.PSELx_i   = 1'b0;
    apb.PENABLE_i = 1'b0;
    apb.PADDR_i   = 32'h0;
    apb.PWRITE_i  = 1'b0;
    apb.PPROT_i   = 3'b000;
    apb.PWDATA_i  = 32'h0;
    apb.PSTRB_i   = 4'h0;
    #1;
    test_reset();
    test_reset_midxfer();
    test_basic();
    test_wait_strobe();
    test_errors();
    test_secure();
    test_abort();
    test_back_to_back();
    test_errcnt_saturation();
    test_idle_outputs();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got no completion by 200000 time units, required completion");
    $fatal(1, "watchdog expired");
  end
endmodule
